// File: rtl/sa_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sa_pkg                                                       |
// | Description : Shared constants and types for the 3x3 systolic feeder.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package sa_pkg;

  localparam int SA_DW     = 8;
  localparam int SA_N      = 3;
  localparam int FRAME_LEN = 4;
  // Per-lane extra delay applied after the common register stage
  localparam int LANE_SKEW [SA_N] = '{0, 1, 2};

  typedef logic signed [SA_DW-1:0] elem_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } feed_state_e;

endpackage
`default_nettype wire

// File: rtl/sa_skew_line.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sa_skew_line                                                 |
// | Description : Zero-reset register delay line; DEPTH of 0 is a pass-through.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sa_skew_line #(
  parameter int DW    = 8,
  parameter int DEPTH = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  if (DEPTH == 0) begin : g_pass
    logic w_unused_clk_rst;
    assign w_unused_clk_rst = clk ^ rst_n;
    assign dout = din;
  end else begin : g_dly
    logic [DW-1:0] r_tap [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) r_tap[i] <= '0;
      end else begin
        r_tap[0] <= din;
        for (int i = 1; i < DEPTH; i++) r_tap[i] <= r_tap[i-1];
      end
    end

    assign dout = r_tap[DEPTH-1];
  end

endmodule
`default_nettype wire

// File: rtl/sa_operand_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sa_operand_feeder                                            |
// | Description : Ping-pong operand buffer emitting skewed x/y lanes + start.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sa_operand_feeder
  import sa_pkg::*;
#(
  parameter int DW = SA_DW,
  parameter int N  = SA_N
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [N*DW-1:0]      ld_a_row,
  input  logic [N*DW-1:0]      ld_b_col,
  output logic                 sa_start,
  output logic signed [DW-1:0] x_1,
  output logic signed [DW-1:0] x_2,
  output logic signed [DW-1:0] x_3,
  output logic signed [DW-1:0] y_1,
  output logic signed [DW-1:0] y_2,
  output logic signed [DW-1:0] y_3,
  output logic                 frm_data,
  output logic                 busy
);

  localparam logic [1:0] c_last_slot = 2'(FRAME_LEN - 1);
  localparam logic [1:0] c_last_beat = 2'(N - 1);

  // [bank][row/col index][element]
  logic [DW-1:0] r_arow [2][N][N];
  logic [DW-1:0] r_bcol [2][N][N];

  logic [1:0]    r_full;
  logic          r_wr_bank;
  logic          r_rd_bank;
  logic [1:0]    r_beat;
  feed_state_e   r_state;
  feed_state_e   w_state_nxt;
  logic [1:0]    r_slot;
  logic [1:0]    w_slot_nxt;
  logic          r_start;
  logic          r_frm;
  logic          w_ld_fire;
  logic          w_fill_done;
  logic          w_release;
  logic          w_other_ready;
  logic [DW-1:0] w_xs [N];
  logic [DW-1:0] w_ys [N];
  logic [DW-1:0] r_xs [N];
  logic [DW-1:0] r_ys [N];
  logic [DW-1:0] w_x  [N];
  logic [DW-1:0] w_y  [N];

  assign ld_ready    = !r_full[r_wr_bank];
  assign w_ld_fire   = ld_valid && ld_ready;
  assign w_fill_done = w_ld_fire && (r_beat == c_last_beat);
  assign w_release   = (r_state == ST_STREAM) && (r_slot == c_last_slot);
  // A fill landing on the release edge still counts, so the frame follows with no bubble
  assign w_other_ready = r_full[!r_rd_bank] || (w_fill_done && (r_wr_bank != r_rd_bank));

  always_ff @(posedge clk) begin
    if (w_ld_fire) begin
      for (int k = 0; k < N; k++) begin
        r_arow[r_wr_bank][r_beat][k] <= ld_a_row[DW*k +: DW];
        r_bcol[r_wr_bank][r_beat][k] <= ld_b_col[DW*k +: DW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat    <= '0;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_full    <= '0;
    end else begin
      if (w_ld_fire) begin
        if (w_fill_done) begin
          r_beat    <= '0;
          r_wr_bank <= !r_wr_bank;
        end else begin
          r_beat <= r_beat + 2'd1;
        end
      end
      if (w_release) begin
        r_full[r_rd_bank] <= 1'b0;
        r_rd_bank         <= !r_rd_bank;
      end
      if (w_fill_done) r_full[r_wr_bank] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_slot  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_slot  <= w_slot_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_slot_nxt  = r_slot + 2'd1;
    case (r_state)
      ST_IDLE: begin
        w_slot_nxt = '0;
        if (r_full[r_rd_bank]) w_state_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        if (r_slot == c_last_slot) w_state_nxt = w_other_ready ? ST_STREAM : ST_DRAIN;
      end
      ST_DRAIN: begin
        if (r_slot == c_last_slot) w_state_nxt = r_full[r_rd_bank] ? ST_STREAM : ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_slot_nxt  = '0;
      end
    endcase
  end

  // Slot 3 of every frame is the zero pad between products
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_xs[i] = '0;
      w_ys[i] = '0;
      if ((r_state == ST_STREAM) && (r_slot != c_last_slot)) begin
        w_xs[i] = r_arow[r_rd_bank][i][r_slot];
        w_ys[i] = r_bcol[r_rd_bank][i][r_slot];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        r_xs[i] <= '0;
        r_ys[i] <= '0;
      end
      r_start <= 1'b0;
      r_frm   <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        r_xs[i] <= w_xs[i];
        r_ys[i] <= w_ys[i];
      end
      r_start <= (r_state != ST_IDLE);
      r_frm   <= (r_state == ST_STREAM) && (r_slot == 2'd0);
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_lane
    sa_skew_line #(.DW(DW), .DEPTH(LANE_SKEW[g])) u_x_skew (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (r_xs[g]),
      .dout (w_x[g])
    );
    sa_skew_line #(.DW(DW), .DEPTH(LANE_SKEW[g])) u_y_skew (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (r_ys[g]),
      .dout (w_y[g])
    );
  end

  assign x_1      = w_x[0];
  assign x_2      = w_x[1];
  assign x_3      = w_x[2];
  assign y_1      = w_y[0];
  assign y_2      = w_y[1];
  assign y_3      = w_y[2];
  assign sa_start = r_start;
  assign frm_data = r_frm;
  assign busy     = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sa_operand_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sa_operand_feeder                                         |
// | Description : Directed scoreboard bench for the systolic operand feeder.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_sa_operand_feeder;
  import sa_pkg::*;

  localparam int DW = SA_DW;

  typedef struct packed {
    elem_t [2:0][2:0] a;   // a[row][col]
    elem_t [2:0][2:0] b;   // b[row][col]
  } job_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 ld_valid = 1'b0;
  logic                 ld_ready;
  logic [3*DW-1:0]      ld_a_row = '0;
  logic [3*DW-1:0]      ld_b_col = '0;
  logic                 sa_start;
  logic signed [DW-1:0] x_1, x_2, x_3, y_1, y_2, y_3;
  logic                 frm_data;
  logic                 busy;

  sa_operand_feeder #(.DW(DW), .N(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ld_valid(ld_valid),
    .ld_ready(ld_ready),
    .ld_a_row(ld_a_row),
    .ld_b_col(ld_b_col),
    .sa_start(sa_start),
    .x_1     (x_1),
    .x_2     (x_2),
    .x_3     (x_3),
    .y_1     (y_1),
    .y_2     (y_2),
    .y_3     (y_3),
    .frm_data(frm_data),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  job_t sb_q[$];
  job_t act_j[$];
  int   act_t[$];
  int   frm_cyc[$];
  int   beat_cyc[$];
  int   last_beat = 0;
  int   run_len = 0;
  int   last_run = 0;
  logic prev_start = 1'b0;

  // Frame start pops a job; each lane i carries element d at frame offset d+i
  initial begin : mon
    logic signed [DW-1:0] ex, ey;
    logic signed [DW-1:0] xo [3];
    logic signed [DW-1:0] yo [3];
    int d;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb_q.delete();
        act_j.delete();
        act_t.delete();
        run_len    = 0;
        last_run   = 0;
        prev_start = 1'b0;
      end else begin
        if (frm_data === 1'b1) begin
          frm_cyc.push_back(cyc);
          chk("frm_with_start", sa_start, 1);
          chk("frm_has_job", (sb_q.size() > 0), 1);
          if (sb_q.size() > 0) begin
            act_j.push_back(sb_q.pop_front());
            act_t.push_back(cyc);
          end
        end
        while (act_t.size() > 0 && cyc > act_t[0] + 5) begin
          act_t.delete(0);
          act_j.delete(0);
        end
        xo = '{x_1, x_2, x_3};
        yo = '{y_1, y_2, y_3};
        for (int i = 0; i < 3; i++) begin
          ex = '0;
          ey = '0;
          for (int f = 0; f < act_t.size(); f++) begin
            d = cyc - act_t[f] - i;
            if (d >= 0 && d <= 2) begin
              ex = act_j[f].a[i][d];
              ey = act_j[f].b[d][i];
            end
          end
          chk($sformatf("x_%0d@%0d", i + 1, cyc), xo[i], ex);
          chk($sformatf("y_%0d@%0d", i + 1, cyc), yo[i], ey);
        end
        if (sa_start === 1'b1) run_len++;
        else if (prev_start) begin
          last_run = run_len;
          run_len  = 0;
        end
        prev_start = sa_start;
      end
    end
  end

  // Caller enters just after a rising edge; ld_valid stays high on return
  task automatic load_mat(input job_t j);
    for (int r = 0; r < 3; r++) begin
      bit ok;
      ok = 1'b0;
      ld_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
        ld_a_row[DW*k +: DW] = j.a[r][k];
        ld_b_col[DW*k +: DW] = j.b[k][r];
      end
      for (int t = 0; t < 50 && !ok; t++) begin
        @(negedge clk);
        if (ld_ready === 1'b1) begin
          ok = 1'b1;
          beat_cyc.push_back(cyc);
          last_beat = cyc;
        end
        @(posedge clk);
        #1;
      end
      chk("beat_accept", ok, 1);
    end
    sb_q.push_back(j);
  endtask

  task automatic wait_frm(output int t);
    bit got;
    got = 1'b0;
    t = -1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (frm_data === 1'b1) begin
        got = 1'b1;
        t = cyc;
      end
    end
    chk("frm_timeout", got, 1);
  endtask

  task automatic wait_idle();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (busy === 1'b0 && sa_start === 1'b0) got = 1'b1;
    end
    chk("idle_timeout", got, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ready"}, ld_ready, 1);
    chk({tag, "_start"}, sa_start, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_frm"}, frm_data, 0);
    chk({tag, "_lanes"}, {x_1, x_2, x_3, y_1, y_2, y_3}, 0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    job_t m1, m2, m3, mx;
    int t1, t2, lb, n0, b0;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 3; k++) begin
        m1.a[r][k] = elem_t'(3 * r + k + 1);
        m1.b[r][k] = (r == k) ? elem_t'(1) : elem_t'(0);
        m2.a[r][k] = elem_t'(10 + 7 * r - 3 * k);
        m2.b[r][k] = elem_t'(-(3 * r + k) - 1);
        m3.a[r][k] = elem_t'(20 * r - 9 * k - 5);
        m3.b[r][k] = elem_t'(11 * k - 4 * r + 2);
        mx.a[r][k] = elem_t'(-128);
        mx.b[r][k] = elem_t'(127);
      end
    end

    repeat (3) @(negedge clk);
    chk_quiet("reset");
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single product
    n0 = frm_cyc.size();
    load_mat(m1);
    ld_valid = 1'b0;
    lb = last_beat;
    wait_frm(t1);
    chk("s1_latency", t1 - lb, 3);
    wait_idle();
    chk("s1_start_len", last_run, 8);
    chk("s1_frames", frm_cyc.size() - n0, 1);
    chk_quiet("s1_idle");

    // Back-to-back
    @(posedge clk); #1;
    n0 = frm_cyc.size();
    load_mat(m2);
    load_mat(m3);
    ld_valid = 1'b0;
    wait_idle();
    chk("s2_frames", frm_cyc.size() - n0, 2);
    chk("s2_gap", (frm_cyc.size() >= n0 + 2) ? frm_cyc[n0+1] - frm_cyc[n0] : -1, 4);
    chk("s2_start_len", last_run, 12);

    // Backpressure with ld_valid held high
    @(posedge clk); #1;
    n0 = frm_cyc.size();
    b0 = beat_cyc.size();
    load_mat(m1);
    load_mat(m2);
    load_mat(m3);
    ld_valid = 1'b0;
    wait_idle();
    chk("s3_beats", beat_cyc.size() - b0, 9);
    chk("s3_burst6", (beat_cyc.size() >= b0 + 9) ? beat_cyc[b0+5] - beat_cyc[b0] : -1, 5);
    chk("s3_stall", (beat_cyc.size() >= b0 + 9) ? beat_cyc[b0+6] - beat_cyc[b0+5] : -1, 3);
    chk("s3_tail", (beat_cyc.size() >= b0 + 9) ? beat_cyc[b0+8] - beat_cyc[b0+6] : -1, 2);
    chk("s3_frames", frm_cyc.size() - n0, 3);
    chk("s3_start_len", last_run, 16);

    // Signed extremes
    @(posedge clk); #1;
    load_mat(mx);
    ld_valid = 1'b0;
    wait_frm(t1);
    chk("s4_x1_min", x_1, -128);
    chk("s4_y1_max", y_1, 127);
    chk("s4_x2_pad", x_2, 0);
    wait_idle();
    chk("s4_start_len", last_run, 8);

    // Asynchronous reset mid-stream, then a clean repeat of the first product
    @(posedge clk); #1;
    load_mat(m1);
    ld_valid = 1'b0;
    wait_frm(t1);
    #2 rst_n = 1'b0;
    #1;
    chk_quiet("s5_async");
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    n0 = frm_cyc.size();
    load_mat(m1);
    ld_valid = 1'b0;
    lb = last_beat;
    wait_frm(t2);
    chk("s5_latency", t2 - lb, 3);
    wait_idle();
    chk("s5_start_len", last_run, 8);
    chk("s5_frames", frm_cyc.size() - n0, 1);

    // Second matrix completes in the second DRAIN cycle
    @(posedge clk); #1;
    n0 = frm_cyc.size();
    load_mat(m2);
    ld_valid = 1'b0;
    wait_frm(t1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    load_mat(m3);
    ld_valid = 1'b0;
    chk("s6_load_in_drain", last_beat - t1, 4);
    wait_idle();
    chk("s6_frames", frm_cyc.size() - n0, 2);
    chk("s6_gap", (frm_cyc.size() >= n0 + 2) ? frm_cyc[n0+1] - frm_cyc[n0] : -1, 8);
    chk("s6_start_len", last_run, 16);

    chk("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
